// File: rtl/seq_alu_pkg.sv
// Shared opcode, comparison and FSM state types for the sequential ALU.
// Pure definitions: no latency, no flow control.
package seq_alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SHL  = 4'd2,
      OP_SHR  = 4'd3,
      OP_INC  = 4'd4,
      OP_DEC  = 4'd5,
      OP_MSB  = 4'd6,
      OP_LSB  = 4'd7,
      OP_SET  = 4'd8,
      OP_CMP  = 4'd9,
      OP_MUL  = 4'd10,
      OP_SHLN = 4'd11,
      OP_SHRN = 4'd12
   } alu_op_t;

   typedef enum logic [1:0] {
      CMP_EQ = 2'd0,
      CMP_NE = 2'd1,
      CMP_GT = 2'd2,
      CMP_LT = 2'd3
   } cmp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      FIN  = 2'd2
   } salu_state_t;

   function automatic logic is_var_shift(input alu_op_t op);
      return (op == OP_SHLN) || (op == OP_SHRN);
   endfunction

endpackage

// File: rtl/seq_alu_pos_enc.sv
// Highest/lowest set-bit index of a word; combinational, zero latency, no flow control.
// An all-zero input reports 0 as highest and WIDTH-1 as lowest.
module pos_enc #(
   parameter int WIDTH = 8,
   parameter int IW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a_i,
   output logic [IW-1:0]    hi_o,
   output logic [IW-1:0]    lo_o
);

   always_comb begin
      hi_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (a_i[i]) hi_o = IW'(i);
      end
   end

   always_comb begin
      lo_o = IW'(WIDTH - 1);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (a_i[i]) lo_o = IW'(i);
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with Start/Busy/Done: single-cycle ops finish in 1 cycle, MUL in WIDTH+1, SHLN/SHRN in N+1.
// No backpressure: Start is only honoured in IDLE and is dropped otherwise.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] InputA,
   input  logic [WIDTH-1:0] InputB,
   input  logic [3:0]       AluOp,
   input  logic [1:0]       ComparisonType,
   input  logic             CarryIn,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] AluOut,
   output logic [WIDTH-1:0] AluOutHi,
   output logic             CarryOut,
   output logic             ZeroOut
);

   localparam int IW = $clog2(WIDTH);

   salu_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   alu_op_t          op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             co_q, co_d;
   logic             z_q, z_d;

   alu_op_t          op_in;
   logic [IW-1:0]    shamt;
   logic [IW-1:0]    msb_idx, lsb_idx;
   logic [WIDTH:0]   sum_w, dif_w, mac_w;
   logic [WIDTH-1:0] s_lo;
   logic             s_co;
   logic [WIDTH-1:0] mul_acc_n, mul_b_n, sh_n;
   logic             sh_co;

   assign op_in = alu_op_t'(AluOp);
   assign shamt = InputB[IW-1:0];

   pos_enc #(.WIDTH(WIDTH), .IW(IW)) u_pos_enc (
      .a_i  (InputA),
      .hi_o (msb_idx),
      .lo_o (lsb_idx)
   );

   // Single-cycle results, computed straight from the ports in the accept cycle.
   always_comb begin
      s_lo  = '0;
      s_co  = 1'b0;
      sum_w = {1'b0, InputA} + {1'b0, InputB} + {{WIDTH{1'b0}}, CarryIn};
      dif_w = {1'b0, InputA} - {1'b0, InputB} - {{WIDTH{1'b0}}, CarryIn};
      case (op_in)
         OP_ADD:  {s_co, s_lo} = sum_w;
         OP_SUB:  {s_co, s_lo} = dif_w;
         OP_SHL:  {s_co, s_lo} = {InputA, CarryIn};
         OP_SHR:  {s_lo, s_co} = {CarryIn, InputA};
         OP_INC:  s_lo = InputA + WIDTH'(1);
         OP_DEC:  s_lo = InputA - WIDTH'(1);
         OP_MSB:  s_lo = {{(WIDTH-IW){1'b0}}, msb_idx};
         OP_LSB:  s_lo = {{(WIDTH-IW){1'b0}}, lsb_idx};
         OP_SET:  s_lo = InputA | (WIDTH'(1) << shamt);
         OP_CMP: begin
            case (cmp_t'(ComparisonType))
               CMP_EQ:  s_lo = {{(WIDTH-1){1'b0}}, InputA == InputB};
               CMP_NE:  s_lo = {{(WIDTH-1){1'b0}}, InputA != InputB};
               CMP_GT:  s_lo = {{(WIDTH-1){1'b0}}, InputA >  InputB};
               CMP_LT:  s_lo = {{(WIDTH-1){1'b0}}, InputA <  InputB};
               default: s_lo = '0;
            endcase
         end
         OP_SHLN, OP_SHRN: s_lo = InputA;
         default: s_lo = '0;
      endcase
   end

   // One iteration step: {acc, b} forms the shifting product register for MUL.
   always_comb begin
      mac_w     = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
      mul_acc_n = mac_w[WIDTH:1];
      mul_b_n   = {mac_w[0], b_q[WIDTH-1:1]};
      if (op_q == OP_SHLN) begin
         sh_n  = {a_q[WIDTH-2:0], 1'b0};
         sh_co = a_q[WIDTH-1];
      end else begin
         sh_n  = {1'b0, a_q[WIDTH-1:1]};
         sh_co = a_q[0];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      co_d    = co_q;
      z_d     = z_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               op_d  = op_in;
               a_d   = InputA;
               b_d   = InputB;
               acc_d = '0;
               if (op_in == OP_MUL) begin
                  cnt_d   = CNT_W'(WIDTH);
                  state_d = EXEC;
               end else if (is_var_shift(op_in) && (shamt != '0)) begin
                  cnt_d   = {{(CNT_W-IW){1'b0}}, shamt};
                  state_d = EXEC;
               end else begin
                  lo_d    = s_lo;
                  hi_d    = '0;
                  co_d    = s_co;
                  z_d     = (s_lo == '0);
                  state_d = FIN;
               end
            end
         end
         EXEC: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (op_q == OP_MUL) begin
               acc_d = mul_acc_n;
               b_d   = mul_b_n;
            end else begin
               a_d = sh_n;
            end
            if (cnt_q == CNT_W'(1)) begin
               state_d = FIN;
               if (op_q == OP_MUL) begin
                  lo_d = mul_b_n;
                  hi_d = mul_acc_n;
                  co_d = |mul_acc_n;
                  z_d  = (mul_b_n == '0);
               end else begin
                  lo_d = sh_n;
                  hi_d = '0;
                  co_d = sh_co;
                  z_d  = (sh_n == '0);
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= OP_ADD;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         co_q    <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         co_q    <= co_d;
         z_q     <= z_d;
      end
   end

   assign Busy     = (state_q != IDLE);
   assign Done     = (state_q == FIN);
   assign AluOut   = lo_q;
   assign AluOutHi = hi_q;
   assign CarryOut = co_q;
   assign ZeroOut  = z_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed check of seq_alu (WIDTH=8) against an arithmetic reference model.
module tb_seq_alu;
   import seq_alu_pkg::*;

   localparam int W = 8;

   logic         Clk = 1'b0;
   logic         Reset, Start, CarryIn;
   logic [W-1:0] InputA, InputB;
   logic [3:0]   AluOp;
   logic [1:0]   ComparisonType;
   logic         Busy, Done, CarryOut, ZeroOut;
   logic [W-1:0] AluOut, AluOutHi;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         c;
      int           lat;
   } exp_t;

   exp_t last_e;

   seq_alu #(.WIDTH(W)) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .Start          (Start),
      .InputA         (InputA),
      .InputB         (InputB),
      .AluOp          (AluOp),
      .ComparisonType (ComparisonType),
      .CarryIn        (CarryIn),
      .Busy           (Busy),
      .Done           (Done),
      .AluOut         (AluOut),
      .AluOutHi       (AluOutHi),
      .CarryOut       (CarryOut),
      .ZeroOut        (ZeroOut)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input int op, input int a, input int b, input int cmp, input int cin);
      exp_t e;
      int   n, r;
      e.lo = '0; e.hi = '0; e.c = 1'b0; e.lat = 1;
      n = b % W;
      case (op)
         int'(OP_ADD): begin r = a + b + cin; e.lo = W'(r); e.c = (r >= (1 << W)); end
         int'(OP_SUB): begin e.lo = W'(a - b - cin); e.c = (a < b + cin); end
         int'(OP_SHL): begin e.lo = W'((a << 1) | cin); e.c = ((a >> (W - 1)) & 1) != 0; end
         int'(OP_SHR): begin e.lo = W'((a >> 1) | (cin << (W - 1))); e.c = (a & 1) != 0; end
         int'(OP_INC): e.lo = W'(a + 1);
         int'(OP_DEC): e.lo = W'(a - 1);
         int'(OP_MSB): begin
            r = 0;
            for (int i = 0; i < W; i++) if (((a >> i) & 1) != 0) r = i;
            e.lo = W'(r);
         end
         int'(OP_LSB): begin
            r = W - 1;
            for (int i = W - 1; i >= 0; i--) if (((a >> i) & 1) != 0) r = i;
            e.lo = W'(r);
         end
         int'(OP_SET): e.lo = W'(a | (1 << n));
         int'(OP_CMP): begin
            case (cmp)
               0: e.lo = W'(a == b);
               1: e.lo = W'(a != b);
               2: e.lo = W'(a > b);
               default: e.lo = W'(a < b);
            endcase
         end
         int'(OP_MUL): begin
            r = a * b; e.lo = W'(r); e.hi = W'(r >> W); e.c = (e.hi != 0); e.lat = W + 1;
         end
         int'(OP_SHLN): begin
            e.lo = W'(a << n); e.c = (n != 0) && (((a >> (W - n)) & 1) != 0); e.lat = n + 1;
         end
         int'(OP_SHRN): begin
            e.lo = W'(a >> n); e.c = (n != 0) && (((a >> (n - 1)) & 1) != 0); e.lat = n + 1;
         end
         default: ;
      endcase
      return e;
   endfunction

   // pre=1: inputs are driven in the current cycle without first waiting a cycle.
   // inject=1: a stray ADD Start is pulsed while the operation is busy.
   task automatic run_op(input int op, input int a, input int b, input int cmp, input int cin,
                         input bit pre, input bit inject);
      exp_t e;
      int   lat;
      e = model(op, a, b, cmp, cin);
      last_e = e;
      if (!pre) @(negedge Clk);
      AluOp = 4'(op); InputA = W'(a); InputB = W'(b);
      ComparisonType = 2'(cmp); CarryIn = 1'(cin); Start = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      lat = 1;
      chk($sformatf("op%0d_busy", op), Busy, 1'b1);
      while (!Done && lat < 40) begin
         if (inject && lat == 2) begin
            Start = 1'b1; AluOp = 4'(OP_ADD); InputA = 8'h01; InputB = 8'h01;
         end else begin
            Start = 1'b0;
         end
         @(negedge Clk);
         lat++;
      end
      Start = 1'b0;
      chk($sformatf("op%0d_done", op), Done, 1'b1);
      chk($sformatf("op%0d_lat", op), lat, e.lat);
      chk($sformatf("op%0d_lo a=%0h b=%0h", op, a, b), AluOut, e.lo);
      chk($sformatf("op%0d_hi", op), AluOutHi, e.hi);
      chk($sformatf("op%0d_co a=%0h b=%0h", op, a, b), CarryOut, e.c);
      chk($sformatf("op%0d_zero", op), ZeroOut, e.lo == '0);
   endtask

   task automatic check_hold();
      @(negedge Clk);
      chk("hold_done", Done, 1'b0);
      chk("hold_busy", Busy, 1'b0);
      chk("hold_lo", AluOut, last_e.lo);
      chk("hold_hi", AluOutHi, last_e.hi);
   endtask

   initial begin
      int op, a, b, seen_done;
      Reset = 1'b1; Start = 1'b0; AluOp = '0; InputA = '0; InputB = '0;
      ComparisonType = '0; CarryIn = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_done", Done, 1'b0);
      chk("rst_lo", AluOut, '0);
      chk("rst_hi", AluOutHi, '0);
      chk("rst_co", CarryOut, 1'b0);
      chk("rst_zero", ZeroOut, 1'b0);
      Reset = 1'b0;

      run_op(int'(OP_ADD), 'hF0, 'h10, 0, 1, 1'b0, 1'b0);
      check_hold();

      // Reset three cycles into a MUL must abort it silently and clear the outputs.
      @(negedge Clk);
      AluOp = 4'(OP_MUL); InputA = 8'hFF; InputB = 8'hFF; Start = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("midrst_busy", Busy, 1'b0);
      chk("midrst_done", Done, 1'b0);
      chk("midrst_lo", AluOut, '0);
      chk("midrst_hi", AluOutHi, '0);
      chk("midrst_co", CarryOut, 1'b0);
      seen_done = 0;
      repeat (12) begin
         @(negedge Clk);
         if (Done) seen_done++;
      end
      chk("midrst_no_done", seen_done, 0);

      run_op(int'(OP_MUL), 'hFF, 'hFF, 0, 0, 1'b0, 1'b0);
      run_op(int'(OP_ADD), 'hFF, 'h01, 0, 0, 1'b0, 1'b0);
      run_op(int'(OP_SHLN), 'hB1, 11, 0, 0, 1'b0, 1'b0);
      run_op(int'(OP_SHLN), 'hB1, 8, 0, 0, 1'b0, 1'b0);
      run_op(int'(OP_SHRN), 'h96, 5, 0, 1, 1'b0, 1'b0);

      // Stray Start while busy, then a Start held through the Done cycle.
      run_op(int'(OP_MUL), 'hFF, 'hFF, 0, 0, 1'b0, 1'b1);
      AluOp = 4'(OP_INC); InputA = 8'hFF; InputB = 8'h00; Start = 1'b1;
      @(negedge Clk);
      chk("done_cycle_start_busy", Busy, 1'b0);
      chk("done_cycle_start_done", Done, 1'b0);
      chk("done_cycle_start_lo", AluOut, 8'h01);
      run_op(int'(OP_INC), 'hFF, 0, 0, 0, 1'b1, 1'b0);
      check_hold();

      run_op(int'(OP_MSB), 'h00, 0, 0, 0, 1'b0, 1'b0);
      run_op(int'(OP_LSB), 'h00, 0, 0, 0, 1'b0, 1'b0);
      run_op(int'(OP_LSB), 'h28, 0, 0, 0, 1'b0, 1'b0);
      run_op(int'(OP_CMP), 3, 200, int'(CMP_LT), 0, 1'b0, 1'b0);
      run_op(int'(OP_SUB), 'h05, 'h05, 0, 1, 1'b0, 1'b0);

      for (int k = 0; k < 200; k++) begin
         op = $urandom_range(0, 12);
         a  = $urandom_range(0, 255);
         b  = $urandom_range(0, 255);
         if ($urandom_range(0, 7) == 0) a = 0;
         run_op(op, a, b, $urandom_range(0, 3), $urandom_range(0, 1), 1'b0, 1'b0);
         if ((k % 4) == 0) check_hold();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, clocked successor to the combinational datapath ALU. Adds generic width, registered results with a Start/Busy/Done handshake, and multi-cycle operations: an iterative shift-add multiply and shifts by a variable distance.
- Sits between the register file and writeback. The control unit stalls the fetch stage while Busy is high.

Parameters:
- WIDTH, 8, datapath width in bits. Must be 4 or more and a power of two.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter. Derived; do not override.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  accept the operands and opcode this cycle; honoured only in IDLE
- InputA  in  WIDTH  operand A, sampled when Start is accepted
- InputB  in  WIDTH  operand B, sampled when Start is accepted
- AluOp  in  4  opcode (alu_op_t), sampled when Start is accepted
- ComparisonType  in  2  comparison select for OP_CMP (cmp_t)
- CarryIn  in  1  carry/borrow/shift-in bit, sampled when Start is accepted
- Busy  out  1  high from the cycle after acceptance until Done
- Done  out  1  one-cycle pulse; results are valid in this cycle and held until the next acceptance
- AluOut  out  WIDTH  result, low word
- AluOutHi  out  WIDTH  high word of OP_MUL; 0 for every other operation
- CarryOut  out  1  carry or shift-out bit
- ZeroOut  out  1  high when AluOut == 0, evaluated on the final result

Behaviour:
- Reset: state goes to IDLE. Busy, Done, AluOut, AluOutHi, CarryOut and ZeroOut all go to 0. Reset mid-operation aborts the operation with no Done pulse.
- FSM states:
  - IDLE: Start=1 latches the operands and goes to EXEC for multi-cycle ops, or straight to FIN for single-cycle ops.
  - EXEC: count down; when the counter reaches 0, go to FIN.
  - FIN: drive Done=1 and return to IDLE.
- Start outside IDLE is ignored. No queueing.
- Single-cycle ops: Start accepted in cycle t gives Done in t+1.
  - OP_ADD: {CarryOut, AluOut} = A + B + CarryIn, computed at WIDTH+1 bits.
  - OP_SUB: AluOut = A - B - CarryIn, truncated to WIDTH. CarryOut = 1 on borrow, i.e. when A < B + CarryIn.
  - OP_INC, OP_DEC: A ± 1, wrapping. CarryOut = 0.
  - OP_SHL: {CarryOut, AluOut} = {A, CarryIn}.
  - OP_SHR: {AluOut, CarryOut} = {CarryIn, A}.
  - OP_MSB: index of the highest set bit of A. If A == 0, the result is 0.
  - OP_LSB: index of the lowest set bit of A. If A == 0, the result is WIDTH-1.
  - OP_SET: AluOut = A with bit B[$clog2(WIDTH)-1:0] set to 1.
  - OP_CMP: AluOut = 1 or 0 for EQ, NE, GT or LT, all unsigned. Any other ComparisonType code gives 0.
  - Undefined opcode: all result outputs are 0.
- OP_MUL (unsigned, WIDTH×WIDTH):
  - One shift-add step per EXEC cycle, WIDTH cycles in total. Done arrives in t+WIDTH+1.
  - {AluOutHi, AluOut} is the full 2·WIDTH-bit product. CarryOut = |AluOutHi.
- OP_SHLN, OP_SHRN (logical shift by N = B mod WIDTH):
  - One bit per EXEC cycle. CarryOut is the last bit shifted out.
  - N == 0 skips EXEC: Done in t+1, AluOut = A, CarryOut = 0.
  - Otherwise Done in t+N+1.
- Outputs change only on entry to FIN. Done is never asserted in the same cycle as Start.
- Back-to-back: a new Start may be driven in the cycle after Done (state is IDLE again). A Start sampled during the Done cycle itself is ignored.
- ZeroOut reflects AluOut only. It ignores AluOutHi.

Decomposition:
- Package definitions (extend it):
  - alu_op_t enum, 4 bits: OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_INC, OP_DEC, OP_MSB, OP_LSB, OP_SET, OP_CMP, OP_MUL, OP_SHLN, OP_SHRN.
  - cmp_t enum: CMP_EQ, CMP_NE, CMP_GT, CMP_LT.
  - salu_state_t enum: IDLE, EXEC, FIN.
- Sub-module pos_enc #(WIDTH): combinational highest-set and lowest-set bit index, instantiated once. Used for OP_MSB and OP_LSB.
- All remaining logic lives in seq_alu: FSM, counter, operand/accumulator registers, result registers.

Test Plan:
- Reset mid-MUL: Start OP_MUL A=8'hFF B=8'hFF, assert Reset at cycle 3 → no Done pulse, all outputs 0, Busy=0 on the next cycle.
- MUL: A=8'hFF B=8'hFF → Done exactly 9 cycles after Start; AluOutHi=8'hFE, AluOut=8'h01, CarryOut=1, ZeroOut=0.
- ADD carry: A=8'hF0 B=8'h10 CarryIn=1 → Done at t+1; AluOut=8'h01, CarryOut=1. Then A=8'hFF B=8'h01 CarryIn=0 → AluOut=8'h00, ZeroOut=1.
- SHLN: A=8'b1011_0001 B=8'd11 (N=3) → Done at t+4; AluOut=8'b1000_1000, CarryOut=1. Same A with B=8'd8 (N=0) → Done at t+1, AluOut=A, CarryOut=0.
- Handshake: while Busy during MUL, pulse Start with OP_ADD → ignored, MUL result unaffected. Start OP_INC A=8'hFF in the cycle after Done → AluOut=8'h00, ZeroOut=1.
- Priority/compare: OP_MSB A=8'h00 → AluOut=0. OP_LSB A=8'h00 → AluOut=7. OP_LSB A=8'h28 → AluOut=3. OP_CMP LT A=3 B=200 → AluOut=1.
